// File: rtl/clk_div_pkg.sv
// Shared types and the ratio clamp for the programmable clock divider.
package clk_div_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam int MIN_DIV = 2;
  localparam int FN_W    = 32;

  // Requested ratios below MIN_DIV cannot make a 50% clock, so they run as MIN_DIV.
  function automatic logic [FN_W-1:0] eff_ratio(input logic [FN_W-1:0] div_ratio);
    return (div_ratio < FN_W'(MIN_DIV)) ? FN_W'(MIN_DIV) : div_ratio;
  endfunction

endpackage

// File: rtl/clk_div_odd_phase.sv
// Negedge half-cycle extension for odd ratios and the clk_out OR gate.
module clk_div_odd_phase (
  input  logic clk,
  input  logic rst,
  input  logic pos_q,
  input  logic odd_q,
  output logic clk_out
);

  logic neg_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= pos_q & odd_q;
  end

  // pos_q is always low in the last cycle of a period, so neg_q is low at every boundary.
  assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty integer clock divider with a clk-domain tick strobe.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_clamped
);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ratio_q;
  logic             odd_q;
  logic             pos_q;

  logic [DIV_W-1:0] ratio_new;
  logic             clamp_new;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] h_cur;
  logic             wrap;

  assign ratio_new = DIV_W'(eff_ratio(FN_W'(div_ratio)));
  assign clamp_new = (div_ratio < DIV_W'(MIN_DIV));
  assign cnt_inc   = cnt + DIV_W'(1);
  assign h_cur     = ratio_q >> 1;
  assign wrap      = (cnt == ratio_q - DIV_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ratio_q     <= DIV_W'(MIN_DIV);
      odd_q       <= 1'b0;
      pos_q       <= 1'b0;
      tick        <= 1'b0;
      cfg_clamped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick <= 1'b0;
          if (en) begin
            state       <= RUN;
            cnt         <= '0;
            pos_q       <= 1'b1;
            tick        <= 1'b1;
            ratio_q     <= ratio_new;
            odd_q       <= ratio_new[0];
            cfg_clamped <= clamp_new;
          end
        end
        default: begin
          if (wrap && !en) begin
            state <= IDLE;
            cnt   <= '0;
            pos_q <= 1'b0;
            tick  <= 1'b0;
          end else if (wrap) begin
            // New period: latch the request; its high count is at least 1, so pos_q starts high.
            cnt         <= '0;
            pos_q       <= 1'b1;
            tick        <= 1'b1;
            ratio_q     <= ratio_new;
            odd_q       <= ratio_new[0];
            cfg_clamped <= clamp_new;
          end else begin
            cnt   <= cnt_inc;
            pos_q <= (cnt_inc < h_cur);
            tick  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);

  clk_div_odd_phase u_odd_phase (
    .clk     (clk),
    .rst     (rst),
    .pos_q   (pos_q),
    .odd_q   (odd_q),
    .clk_out (clk_out)
  );

endmodule
